imm_decode_pipe: RTL and testbench

//  Pipelined, handshaked immediate decoder for the ID stage. It classifies each

---
 rtl/imm_decode_pipe.sv | 159 +++++++++++++++
 tb/tb_imm_decode_pipe.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/imm_decode_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : imm_decode_pipe
//  Description : Pipelined RISC-V immediate decoder for the ID stage.
//                Classifies the instruction format from the opcode, builds the
//                sign-extended immediate, and carries an opaque tag alongside.
//                Valid/ready on both sides, with an output register plus a
//                skid register so the upstream ready is driven from a flop.
//  Revision    : 1.0  initial release
// ============================================================================
module imm_decode_pipe #(
  parameter int XLEN  = 32,  // 32 or 64
  parameter int TAG_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [31:0]      i_instruction,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [XLEN-1:0]  o_immediate,
  output logic [2:0]       o_fmt,
  output logic [TAG_W-1:0] o_tag
);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_Z    = 3'd6;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // Decoded result of the instruction currently on the input
  logic signed [31:0] dec_imm32;
  logic [XLEN-1:0]    dec_imm;
  logic [2:0]         dec_fmt;

  // Output register (OR) and skid register (SK)
  logic               or_valid;
  logic [XLEN-1:0]    or_imm;
  logic [2:0]         or_fmt;
  logic [TAG_W-1:0]   or_tag;
  logic               sk_valid;
  logic [XLEN-1:0]    sk_imm;
  logic [2:0]         sk_fmt;
  logic [TAG_W-1:0]   sk_tag;

  logic               accept;
  logic               drain;
  logic               or_free;

  // Format classification and field assembly; every format is built as a
  // 32-bit value whose bit 31 is the correct sign (0 for Z and NONE), so one
  // signed widening covers both XLEN settings.
  always_comb begin
    dec_fmt   = FMT_NONE;
    dec_imm32 = '0;
    case (i_instruction[6:0])
      OP_LOAD, OP_IMM, OP_JALR: begin
        dec_fmt   = FMT_I;
        dec_imm32 = {{20{i_instruction[31]}}, i_instruction[31:20]};
      end
      OP_STORE: begin
        dec_fmt   = FMT_S;
        dec_imm32 = {{20{i_instruction[31]}}, i_instruction[31:25], i_instruction[11:7]};
      end
      OP_BRANCH: begin
        dec_fmt   = FMT_B;
        dec_imm32 = {{19{i_instruction[31]}}, i_instruction[31], i_instruction[7],
                     i_instruction[30:25], i_instruction[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        dec_fmt   = FMT_U;
        dec_imm32 = {i_instruction[31:12], 12'h000};
      end
      OP_JAL: begin
        dec_fmt   = FMT_J;
        dec_imm32 = {{11{i_instruction[31]}}, i_instruction[31], i_instruction[19:12],
                     i_instruction[20], i_instruction[30:21], 1'b0};
      end
      OP_SYSTEM: begin
        // Only the immediate CSR forms (funct3[2]=1) carry a zimm field
        if (i_instruction[14]) begin
          dec_fmt   = FMT_Z;
          dec_imm32 = {27'd0, i_instruction[19:15]};
        end
      end
      default: begin
        dec_fmt   = FMT_NONE;
        dec_imm32 = '0;
      end
    endcase
    dec_imm = XLEN'(dec_imm32);
  end

  assign accept  = i_valid && o_ready;
  assign drain   = or_valid && i_ready;
  // OR can take new data this edge when it is empty or being consumed
  assign or_free = !or_valid || drain;

  // Two-entry pipeline: OR feeds the outputs, SK absorbs one beat while OR stalls
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      or_valid <= 1'b0;
      or_imm   <= '0;
      or_fmt   <= FMT_NONE;
      or_tag   <= '0;
      sk_valid <= 1'b0;
      sk_imm   <= '0;
      sk_fmt   <= FMT_NONE;
      sk_tag   <= '0;
    end else begin
      if (or_free) begin
        if (sk_valid) begin
          // Older beat in SK goes first; o_ready is low so nothing is accepted
          or_valid <= 1'b1;
          or_imm   <= sk_imm;
          or_fmt   <= sk_fmt;
          or_tag   <= sk_tag;
          sk_valid <= 1'b0;
        end else if (accept) begin
          or_valid <= 1'b1;
          or_imm   <= dec_imm;
          or_fmt   <= dec_fmt;
          or_tag   <= i_tag;
        end else begin
          or_valid <= 1'b0;
        end
      end else if (accept) begin
        // OR is held by backpressure; park the new beat in SK
        sk_valid <= 1'b1;
        sk_imm   <= dec_imm;
        sk_fmt   <= dec_fmt;
        sk_tag   <= i_tag;
      end
    end
  end

  assign o_ready     = !sk_valid;
  assign o_valid     = or_valid;
  assign o_immediate = or_imm;
  assign o_fmt       = or_fmt;
  assign o_tag       = or_tag;

endmodule
`default_nettype wire

// File: tb/tb_imm_decode_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imm_decode_pipe
//  Description : Self-checking bench for imm_decode_pipe, XLEN=32 and XLEN=64
//                instances driven in lockstep.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_imm_decode_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] instr;
  logic [7:0]  tag;
  logic        out_ready;

  logic        rdy32, vld32, rdy64, vld64;
  logic [31:0] imm32;
  logic [63:0] imm64;
  logic [2:0]  fmt32, fmt64;
  logic [7:0]  tag32, tag64;

  int errors = 0;
  int checks = 0;

  imm_decode_pipe #(.XLEN(32), .TAG_W(8)) dut32 (
    .i_clk(clk), .i_rst(rst), .i_valid(in_valid), .o_ready(rdy32),
    .i_instruction(instr), .i_tag(tag), .o_valid(vld32), .i_ready(out_ready),
    .o_immediate(imm32), .o_fmt(fmt32), .o_tag(tag32)
  );

  imm_decode_pipe #(.XLEN(64), .TAG_W(8)) dut64 (
    .i_clk(clk), .i_rst(rst), .i_valid(in_valid), .o_ready(rdy64),
    .i_instruction(instr), .i_tag(tag), .o_valid(vld64), .i_ready(out_ready),
    .o_immediate(imm64), .o_fmt(fmt64), .o_tag(tag64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic [7:0]  tag;
  } res_t;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] imm;
    logic [2:0]  fmt;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Compare both instances' payload against an expected result
  task automatic chk_res(input string name, input res_t e);
    chk({name, " imm32"}, {32'h0, imm32}, {32'h0, e.imm[31:0]});
    chk({name, " imm64"}, imm64, e.imm);
    chk({name, " fmt32"}, {61'h0, fmt32}, {61'h0, e.fmt});
    chk({name, " fmt64"}, {61'h0, fmt64}, {61'h0, e.fmt});
    chk({name, " tag32"}, {56'h0, tag32}, {56'h0, e.tag});
    chk({name, " tag64"}, {56'h0, tag64}, {56'h0, e.tag});
  endtask

  task automatic chk_flags(input string name, input logic ev, input logic er);
    chk({name, " valid32"}, {63'h0, vld32}, {63'h0, ev});
    chk({name, " valid64"}, {63'h0, vld64}, {63'h0, ev});
    chk({name, " ready32"}, {63'h0, rdy32}, {63'h0, er});
    chk({name, " ready64"}, {63'h0, rdy64}, {63'h0, er});
  endtask

  // Reference decode from the ISA field rules, as a 64-bit signed value
  function automatic res_t model(input logic [31:0] ins, input logic [7:0] t);
    res_t r;
    logic [11:0] f12;
    logic [12:0] f13;
    logic [20:0] f21;
    logic [31:0] f32;
    r.tag = t;
    r.fmt = 3'd0;
    r.imm = 64'd0;
    case (ins[6:0])
      7'b0000011, 7'b0010011, 7'b1100111: begin
        f12 = ins[31:20];
        r.fmt = 3'd1; r.imm = 64'(longint'($signed(f12)));
      end
      7'b0100011: begin
        f12 = {ins[31:25], ins[11:7]};
        r.fmt = 3'd2; r.imm = 64'(longint'($signed(f12)));
      end
      7'b1100011: begin
        f13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        r.fmt = 3'd3; r.imm = 64'(longint'($signed(f13)));
      end
      7'b0110111, 7'b0010111: begin
        f32 = {ins[31:12], 12'h0};
        r.fmt = 3'd4; r.imm = 64'(longint'($signed(f32)));
      end
      7'b1101111: begin
        f21 = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        r.fmt = 3'd5; r.imm = 64'(longint'($signed(f21)));
      end
      7'b1110011: begin
        if (ins[14]) begin
          r.fmt = 3'd6; r.imm = 64'(ins[19:15]);
        end
      end
      default: ;
    endcase
    return r;
  endfunction

  vec_t vecs[10];
  res_t q[$];
  logic [6:0] ops[11];

  initial begin
    vecs[0] = '{32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1}; // addi x1,x0,-1
    vecs[1] = '{32'hFE112E23, 64'hFFFF_FFFF_FFFF_FFFC, 3'd2}; // sw x1,-4(x2)
    vecs[2] = '{32'hFFDFF06F, 64'hFFFF_FFFF_FFFF_FFFC, 3'd5}; // jal x0,-4
    vecs[3] = '{32'h800000B7, 64'hFFFF_FFFF_8000_0000, 3'd4}; // lui x1,0x80000
    vecs[4] = '{32'h300FD073, 64'h0000_0000_0000_001F, 3'd6}; // csrrwi mstatus,31
    vecs[5] = '{32'h002081B3, 64'h0,                   3'd0}; // add (R-type)
    vecs[6] = '{32'h30009073, 64'h0,                   3'd0}; // csrrw: funct3[2]=0
    vecs[7] = '{32'h00000463, 64'h0000_0000_0000_0008, 3'd3}; // beq +8
    vecs[8] = '{32'h12345097, 64'h0000_0000_1234_5000, 3'd4}; // auipc
    vecs[9] = '{32'h7FF00093, 64'h0000_0000_0000_07FF, 3'd1}; // addi 0x7FF

    ops = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h73, 7'h33, 7'h0F};

    rst = 1'b1; in_valid = 1'b1; instr = 32'hFFF00093; tag = 8'hAA; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk_flags("reset", 1'b0, 1'b1);
    chk_res("reset", '{64'h0, 3'd0, 8'h00});
    // Release reset with nothing offered: the beat presented during reset must not appear
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk_flags("after reset", 1'b0, 1'b1);

    // Table vectors, one per cycle with the sink always ready
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; instr = vecs[i].instr; tag = 8'(i + 16);
      @(negedge clk);
      chk_flags($sformatf("vec%0d", i), 1'b1, 1'b1);
      chk_res($sformatf("vec%0d", i), '{vecs[i].imm, vecs[i].fmt, 8'(i + 16)});
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk_flags("table drained", 1'b0, 1'b1);

    // Backpressure: tags 1,2,3 offered back-to-back while the sink stalls
    out_ready = 1'b0;
    in_valid = 1'b1; instr = 32'hFFF00093; tag = 8'd1;
    @(negedge clk);
    chk_flags("bp t1 in OR", 1'b1, 1'b1);
    instr = 32'hFE112E23; tag = 8'd2;
    @(negedge clk);
    chk_flags("bp t2 in SK", 1'b1, 1'b0);
    chk_res("bp hold1", '{64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 8'd1});
    instr = 32'h300FD073; tag = 8'd3;
    @(negedge clk);
    chk_flags("bp t3 held", 1'b1, 1'b0);
    chk_res("bp hold2", '{64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 8'd1});
    out_ready = 1'b1;
    @(negedge clk);
    chk_flags("bp out2", 1'b1, 1'b1);
    chk_res("bp out2", '{64'hFFFF_FFFF_FFFF_FFFC, 3'd2, 8'd2});
    @(negedge clk);
    chk_flags("bp out3", 1'b1, 1'b1);
    chk_res("bp out3", '{64'h1F, 3'd6, 8'd3});
    in_valid = 1'b0;
    @(negedge clk);
    chk_flags("bp empty", 1'b0, 1'b1);

    // Reset with both registers full, then a fresh beat
    out_ready = 1'b0;
    in_valid = 1'b1; instr = 32'h800000B7; tag = 8'd4;
    @(negedge clk);
    instr = 32'hFFDFF06F; tag = 8'd5;
    @(negedge clk);
    chk_flags("full before rst", 1'b1, 1'b0);
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    chk_flags("mid-stall reset", 1'b0, 1'b1);
    chk_res("mid-stall reset", '{64'h0, 3'd0, 8'h00});
    rst = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; instr = 32'h00000463; tag = 8'd6;
    @(negedge clk);
    chk_flags("fresh after rst", 1'b1, 1'b1);
    chk_res("fresh after rst", '{64'h8, 3'd3, 8'd6});
    in_valid = 1'b0;
    @(negedge clk);
    chk_flags("fresh drained", 1'b0, 1'b1);

    // Randomized traffic against a queue model of in-flight results
    q.delete();
    for (int c = 0; c < 3000; c++) begin
      logic acc, drn;
      chk_flags("rand flags", q.size() > 0, q.size() < 2);
      if (q.size() > 0) chk_res("rand payload", q[0]);
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(2) != 0);
      instr     = $urandom;
      if ($urandom_range(7) != 0) instr[6:0] = ops[$urandom_range(10)];
      tag       = 8'($urandom);
      acc = in_valid && (q.size() < 2);
      drn = out_ready && (q.size() > 0);
      if (drn) void'(q.pop_front());
      if (acc) q.push_back(model(instr, tag));
      @(negedge clk);
    end
    in_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
